// File: rtl/irq_pending_ctrl_if.sv
// Bundles the signals between irq_pending_ctrl and its neighbours.
//   irq_in    : asynchronous request lines, bit 3 is the highest priority
//   irq_mask  : 1 hides a pending bit from the encoder (it is still captured)
//   pend_vec  : registered masked pending vector, drives the encoder data_in
//   enc_idx   : encoder index back from the encoder (bit3->00 ... bit0->11)
//   enc_valid : encoder valid (any pend_vec bit set)
//   out_valid : issued request valid
//   out_idx   : issued request index, stable while out_valid
//   out_ready : consumer accepts when out_valid & out_ready
//   overflow  : sticky per-bit flag, a request hit an already pending bit
//   clr_ovf   : one-cycle pulse that clears overflow
// master is the controller side; slave is the encoder/consumer/source side.
interface irq_pending_ctrl_if;
    logic [3:0] irq_in;
    logic [3:0] irq_mask;
    logic [3:0] pend_vec;
    logic [1:0] enc_idx;
    logic       enc_valid;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       out_ready;
    logic [3:0] overflow;
    logic       clr_ovf;

    modport master (
        input  irq_in, irq_mask, enc_idx, enc_valid, out_ready, clr_ovf,
        output pend_vec, out_valid, out_idx, overflow
    );

    modport slave (
        output irq_in, irq_mask, enc_idx, enc_valid, out_ready, clr_ovf,
        input  pend_vec, out_valid, out_idx, overflow
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Request-capture stage in front of a 4-input priority encoder.
// Synchronises four asynchronous request lines, latches capture events into
// a pending register, presents pending & ~irq_mask to the encoder, issues the
// encoder's winning index over a valid/ready handshake and clears the
// serviced pending bit on acceptance.
// Ports:
//   clk   : single clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : irq_pending_ctrl_if.master (requests, mask, encoder feedback,
//           issue handshake, overflow flags)
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2,  // legal 2..4
    parameter int EDGE_MODE   = 1   // 1: rising-edge capture, 0: level capture
) (
    input  logic                clk,
    input  logic                rst_n,
    irq_pending_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Number of post-reset samples needed before sync_out and sync_prev both
    // hold real input history.
    localparam logic [2:0] FILL_FULL = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0] sync_out;
    logic [3:0] sync_prev_q, sync_prev_d;
    logic [2:0] fill_q, fill_d;
    logic [3:0] cap;
    logic [3:0] clr;
    logic [3:0] ovf_set;
    logic [3:0] pending_q, pending_d;
    logic [3:0] pend_vec_q, pend_vec_d;
    logic [3:0] overflow_q, overflow_d;
    state_t     state_q, state_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_idx_q, out_idx_d;
    logic       accept;

    // Synchroniser and capture-event detection.
    // The history registers reset to zero, so a line already high when reset
    // releases would look like a fresh 0->1. Edge capture is therefore held
    // off until two genuine post-reset samples have reached the chain output.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.irq_in};
        sync_out    = sync_q[SYNC_STAGES-1];
        sync_prev_d = sync_out;
        fill_d      = (fill_q == FILL_FULL) ? fill_q : fill_q + 3'd1;
        if (EDGE_MODE != 0) begin
            cap = (fill_q == FILL_FULL) ? (sync_out & ~sync_prev_q) : 4'b0000;
        end else begin
            cap = sync_out;
        end
    end

    assign accept = out_valid_q & bus.out_ready;

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enc_valid) state_d = ISSUE;
            ISSUE:   if (accept)        state_d = SETTLE;
            SETTLE:                     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // FSM outputs: issue register updates and the pending-bit clear.
    // Index 0 corresponds to pending bit 3, hence the right shift of 4'b1000.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        clr         = 4'b0000;
        case (state_q)
            IDLE: begin
                if (bus.enc_valid) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = bus.enc_idx;
                end
            end
            ISSUE: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    clr         = 4'b1000 >> out_idx_q;
                end
            end
            default: ;
        endcase
    end

    // Pending/overflow update. A capture on a bit being cleared in the same
    // cycle re-arms the bit and is not an overflow. A new overflow beats
    // clr_ovf. Level capture never flags overflow.
    always_comb begin
        ovf_set    = (EDGE_MODE != 0) ? (cap & pending_q & ~clr) : 4'b0000;
        pending_d  = (pending_q & ~clr) | cap;
        pend_vec_d = pending_d & ~bus.irq_mask;
        overflow_d = (overflow_q & ~{4{bus.clr_ovf}}) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 4'b0000;
            fill_q      <= 3'd0;
            pending_q   <= 4'b0000;
            pend_vec_q  <= 4'b0000;
            overflow_q  <= 4'b0000;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= 2'b00;
        end else begin
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            fill_q      <= fill_d;
            pending_q   <= pending_d;
            pend_vec_q  <= pend_vec_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.pend_vec  = pend_vec_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios followed by
// randomized traffic, checked against a behavioural model and a scoreboard
// of expected issued indices.
module tb_irq_pending_ctrl;

    localparam int S  = 2;
    localparam int EM = 1;

    logic clk;
    logic rst_n;

    irq_pending_ctrl_if bus ();

    irq_pending_ctrl #(
        .SYNC_STAGES (S),
        .EDGE_MODE   (EM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder in the environment: highest set bit of pend_vec wins.
    always_comb begin
        bus.enc_valid = |bus.pend_vec;
        bus.enc_idx   = 2'd0;
        if      (bus.pend_vec[3]) bus.enc_idx = 2'd0;
        else if (bus.pend_vec[2]) bus.enc_idx = 2'd1;
        else if (bus.pend_vec[1]) bus.enc_idx = 2'd2;
        else if (bus.pend_vec[0]) bus.enc_idx = 2'd3;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // hist holds post-reset irq_in samples, newest first. A request becomes a
    // capture event S edges after it is sampled; in edge mode it also needs
    // the preceding sample to have been 0.
    logic [3:0] hist[$];
    logic [1:0] exp_q[$];
    logic [3:0] m_pend, m_pvec, m_ovf, m_ev, m_clr;
    logic [1:0] m_idx;
    bit         m_busy, m_gap;

    initial begin
        m_pend = 0; m_pvec = 0; m_ovf = 0; m_busy = 0; m_gap = 0; m_idx = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                hist.delete();
                exp_q.delete();
                m_pend = 0; m_pvec = 0; m_ovf = 0; m_busy = 0; m_gap = 0;
            end else begin
                m_ev = 4'b0000;
                if (EM != 0) begin
                    if (hist.size() >= S + 1) m_ev = hist[S-1] & ~hist[S];
                end else if (hist.size() >= S) begin
                    m_ev = hist[S-1];
                end
                hist.push_front(bus.irq_in);
                if (hist.size() > S + 1) void'(hist.pop_back());

                m_clr = 4'b0000;
                if (m_busy) begin
                    if (bus.out_ready) begin
                        m_clr[3 - int'(m_idx)] = 1'b1;
                        m_busy = 0;
                        m_gap  = 1;
                    end
                end else if (m_gap) begin
                    m_gap = 0;
                end else if (m_pvec != 0) begin
                    for (int b = 0; b < 4; b++) if (m_pvec[b]) m_idx = 2'(3 - b);
                    m_busy = 1;
                    exp_q.push_back(m_idx);
                end

                if (bus.clr_ovf) m_ovf = 4'b0000;
                if (EM != 0) m_ovf = m_ovf | (m_ev & m_pend & ~m_clr);
                m_pend = (m_pend & ~m_clr) | m_ev;
                m_pvec = m_pend & ~bus.irq_mask;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] issued[$];
    logic [1:0] held, e_idx;
    bit         prev_v;

    initial begin
        prev_v = 0;
        held   = 0;
        forever begin
            @(negedge clk);
            chk("pend_vec",  bus.pend_vec,  m_pvec);
            chk("overflow",  bus.overflow,  m_ovf);
            chk("out_valid", bus.out_valid, m_busy);
            if (bus.out_valid && !prev_v) begin
                issued.push_back(bus.out_idx);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got idx %0d expected none at %0t", bus.out_idx, $time);
                end else begin
                    e_idx = exp_q.pop_front();
                    chk("sb_out_idx", bus.out_idx, e_idx);
                end
            end else if (bus.out_valid && prev_v) begin
                chk("idx_stable", bus.out_idx, held);
            end
            if (bus.out_valid) held = bus.out_idx;
            prev_v = bus.out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        chk(nm, bus.out_valid, 1'b1);
    endtask

    int n0;

    initial begin
        rst_n = 1'b0;
        bus.irq_in = 4'hF; bus.irq_mask = 4'h0; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;

        // Reset held for two edges with all lines high.
        cyc(2);
        chk("rst_pend_vec",  bus.pend_vec,  4'h0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_overflow",  bus.overflow,  4'h0);
        rst_n = 1'b1;
        cyc(8);
        chk("rst_no_capture", bus.pend_vec, 4'h0);
        chk("rst_no_issue",   bus.out_valid, 1'b0);
        bus.irq_in = 4'h0;
        cyc(4);

        // Single request on bit 1, exact latency.
        bus.irq_in = 4'b0010;
        cyc(1); chk("single_e0_pend", bus.pend_vec, 4'b0000);
        cyc(1); chk("single_e1_pend", bus.pend_vec, 4'b0000);
        cyc(1); chk("single_e2_pend", bus.pend_vec, 4'b0010);
                chk("single_e2_valid", bus.out_valid, 1'b0);
        cyc(1); chk("single_e3_valid", bus.out_valid, 1'b1);
                chk("single_e3_idx",   bus.out_idx,   2'b10);
        bus.out_ready = 1'b1;
        cyc(1); chk("single_e4_pend",  bus.pend_vec,  4'b0000);
                chk("single_e4_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        bus.irq_in = 4'h0;
        cyc(4);

        // Priority: bits 0 and 3 together.
        n0 = issued.size();
        bus.out_ready = 1'b1;
        bus.irq_in = 4'b1001;
        cyc(2);
        bus.irq_in = 4'h0;
        cyc(14);
        chk("prio_count", issued.size() - n0, 2);
        if (issued.size() >= n0 + 2) begin
            chk("prio_first",  issued[n0],     2'b00);
            chk("prio_second", issued[n0 + 1], 2'b11);
        end
        bus.out_ready = 1'b0;

        // Backpressure while bit 3 arrives.
        n0 = issued.size();
        bus.irq_in = 4'b0001;
        cyc(2);
        bus.irq_in = 4'h0;
        wait_valid("bp_first_seen");
        chk("bp_first_idx", bus.out_idx, 2'b11);
        bus.irq_in = 4'b1000;
        cyc(2);
        bus.irq_in = 4'h0;
        cyc(8);
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        chk("bp_hold_idx",   bus.out_idx,   2'b11);
        bus.out_ready = 1'b1;
        cyc(8);
        chk("bp_count", issued.size() - n0, 2);
        if (issued.size() >= n0 + 2) chk("bp_second_idx", issued[n0 + 1], 2'b00);
        bus.out_ready = 1'b0;
        cyc(2);

        // Masked bit 2 pulsed twice, then unmasked, then overflow cleared.
        n0 = issued.size();
        bus.irq_mask = 4'b0100;
        bus.out_ready = 1'b1;
        bus.irq_in = 4'b0100; cyc(2);
        bus.irq_in = 4'h0;    cyc(4);
        bus.irq_in = 4'b0100; cyc(2);
        bus.irq_in = 4'h0;    cyc(6);
        chk("mask_pend_vec", bus.pend_vec, 4'b0000);
        chk("mask_overflow", bus.overflow, 4'b0100);
        chk("mask_no_issue", issued.size() - n0, 0);
        bus.irq_mask = 4'h0;
        cyc(6);
        chk("unmask_count", issued.size() - n0, 1);
        if (issued.size() >= n0 + 1) chk("unmask_idx", issued[n0], 2'b01);
        bus.clr_ovf = 1'b1;
        cyc(1);
        bus.clr_ovf = 1'b0;
        chk("clr_ovf", bus.overflow, 4'b0000);
        bus.out_ready = 1'b0;
        cyc(2);

        // Reset in the middle of an issue; line stays high across reset.
        bus.irq_in = 4'b0001;
        cyc(2);
        wait_valid("rstmid_seen");
        rst_n = 1'b0;
        cyc(1);
        chk("rstmid_valid", bus.out_valid, 1'b0);
        chk("rstmid_pend",  bus.pend_vec,  4'b0000);
        rst_n = 1'b1;
        cyc(6);
        chk("rstmid_no_recapture", bus.pend_vec,  4'b0000);
        chk("rstmid_idle",         bus.out_valid, 1'b0);
        bus.irq_in = 4'h0;
        cyc(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.irq_in    = bus.irq_in ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(15) == 0) bus.irq_mask = 4'($urandom);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.clr_ovf   = ($urandom_range(9) == 0);
            rst_n         = ($urandom_range(199) != 0);
            cyc(1);
        end

        // Drain: everything pending must be issued.
        rst_n = 1'b1;
        bus.irq_in = 4'h0; bus.irq_mask = 4'h0; bus.out_ready = 1'b1; bus.clr_ovf = 1'b0;
        cyc(40);
        chk("sb_drain",    exp_q.size(), 0);
        chk("drain_pend",  bus.pend_vec, 4'h0);
        chk("drain_valid", bus.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
Upstream request-capture stage for the 4-input priority encoder. It synchronises four asynchronous request lines, latches them into a pending register, and presents the masked pending vector to the encoder. It takes the encoder's index/valid back, issues the winning index to a consumer over a valid/ready handshake, and clears the serviced pending bit on acceptance.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each irq_in bit before edge detection (legal 2..4)
EDGE_MODE, 1, 1 = capture on rising edge of synchronised input; 0 = capture while level high

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
irq_in  input  4  asynchronous request lines; bit 3 highest priority
irq_mask  input  4  1 = bit hidden from encoder (still captured into pending)
pend_vec  output  4  pending & ~irq_mask, registered; drives encoder data_in
enc_idx  input  2  encoder index: bit3->00, bit2->01, bit1->10, bit0->11
enc_valid  input  1  encoder valid (any pend_vec bit set)
out_valid  output  1  issued request valid
out_idx  output  2  issued request index, stable while out_valid
out_ready  input  1  consumer accepts when out_valid & out_ready
overflow  output  4  sticky: request arrived on a bit already pending
clr_ovf  input  1  clears overflow (one-cycle pulse)

Behaviour:
- Reset (rst_n=0 at a clk edge): sync chain, edge-detect history, pending, pend_vec, overflow = 0; out_valid=0, out_idx=2'b00; FSM -> IDLE. Applies mid-handshake; in-flight request is dropped, no clear performed.
- Capture event per bit i: EDGE_MODE=1 -> sync_out[i] & ~sync_prev[i]; EDGE_MODE=0 -> sync_out[i].
- Latency: irq_in rising, first sampled at edge k -> pending[i] and pend_vec[i] (if unmasked) high after edge k+SYNC_STAGES; out_valid high after edge k+SYNC_STAGES+1.
- Overflow: capture event on bit already pending sets overflow[i], EDGE_MODE=1 only (level mode never flags). clr_ovf and a new overflow in same cycle -> set wins.
- FSM states IDLE, ISSUE, SETTLE:
  - IDLE: if enc_valid -> register out_idx=enc_idx, out_valid=1, go ISSUE; else stay.
  - ISSUE: out_idx frozen. On out_valid & out_ready: clear pending bit (3-out_idx), out_valid=0, go SETTLE. No handshake -> stay; mask changes do not withdraw the request.
  - SETTLE: one cycle, no issue, lets pend_vec and encoder output update; -> IDLE.
- Max throughput: one issue per 3 cycles with out_ready tied high.
- Simultaneous capture and clear on same bit: capture wins, bit stays pending, no overflow flagged.
- Masked pending bits stay pending indefinitely; unmasking makes them visible on pend_vec next cycle.
- enc_valid sampled only in IDLE; enc_idx ignored otherwise.

Test Plan:
- Reset: hold rst_n=0 two edges with irq_in=4'hF -> pending=0, pend_vec=0, out_valid=0, overflow=0; release -> with EDGE_MODE=1 no capture until a fresh 0->1 on some bit.
- Single request: irq_in[1] 0->1 sampled edge 0, SYNC_STAGES=2 -> pend_vec=4'b0010 after edge 2, out_valid=1 out_idx=2'b10 after edge 3; out_ready=1 at edge 4 -> pend_vec=0 after edge 4, out_valid=0.
- Priority: bits 0 and 3 rise together -> first issue out_idx=2'b00, handshake, SETTLE, then out_idx=2'b11; pend_vec 1001 -> 0001 -> 0000.
- Backpressure: out_ready=0 for 10 cycles during ISSUE while bit 3 arrives -> out_idx holds original value, out_valid stays 1; bit 3 issued next after SETTLE.
- Mask/overflow: irq_mask=4'b0100, pulse bit 2 twice -> pend_vec=0, out_valid never asserts, overflow=4'b0100; unmask -> issue out_idx=2'b01; clr_ovf -> overflow=0.
- Reset mid-ISSUE: rst_n=0 while out_valid=1 -> next edge out_valid=0, pending=0, FSM IDLE.
